hwpe_stream_realign_addressgen: RTL
===================================

# hwpe_stream_realign_addressgen

Word-address and realignment-control generator for misaligned load streams. It takes a byte base address, line length, line count and stride, and emits word-aligned TCDM addresses. With each address it emits the per-word byte strobe and the `ctrl_realign_t` control that `hwpe_stream_source_realign` needs to rebuild a contiguous stream. It sits directly upstream of the source realigner, in the source path between the streamer controller and the TCDM load port.

## Interface
- `DATA_WIDTH`, 32: stream/TCDM word width in bits; `BYTES = DATA_WIDTH/8` (power of two).
- `CNT_WIDTH`, 16: width of the line-length and line-count counters.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, synchronous and active-low; the only reset.
- `clear_i` in 1: synchronous soft clear.
- `enable_i` in 1: when low, the block holds all state.
- `start_i` in 1: one-cycle job start; sampled only in IDLE.
- `base_addr_i` in 32: byte address of the first byte of line 0.
- `line_length_i` in CNT_WIDTH: words per line, payload only.
- `num_lines_i` in CNT_WIDTH: number of lines.
- `line_stride_i` in 32: byte stride between line starts. The low `log2(BYTES)` bits are ignored and treated as 0.
- `addr_ready_i` in 1: the TCDM port accepts the current address.
- `addr_o` out 32: word-aligned byte address.
- `addr_valid_o` out 1: `addr_o` is valid.
- `strb_o` out BYTES: byte strobe for the current word; feeds the realigner `strb_i`.
- `ctrl_realign_o` out ctrl_realign_t: fields enable, realign, first, last, last_packet, line_length.
- `busy_o` out 1: FSM is not in IDLE.
- `done_o` out 1: one-cycle pulse at job end.

## Operation
- **Alignment.** `off = base_addr_i[log2(BYTES)-1:0]`, latched at start. `misaligned = (off != 0)`, constant for the whole job.
- **Words per line.** `W = line_length_i + misaligned`.
- **Addresses.**
  - `line_base` starts at `{base_addr_i[31:log2 BYTES], 0}`.
  - Word k of a line has address `line_base + k*BYTES`.
  - At line end, `line_base += stride_aligned`. The sum wraps modulo 2^32.
- **Strobes when misaligned.**
  - Word 0: `'1 << off`, i.e. popcount `BYTES-off`, the rotation the realigner latches.
  - Words 1..W-2: `'1`.
  - Word W-1: `~('1 << off)`.
- **Strobes when aligned.** `'1` on every word.
- **`ctrl_realign_o` fields.**
  - `enable` = `busy_o`.
  - `realign` = `misaligned`.
  - `first` = (word counter == 0).
  - `last` = (word counter == W-1).
  - `last_packet` = final line AND word W-1.
  - `line_length` = latched `line_length_i`.
- **FSM** (`addressgen_state_t`):
  - IDLE → RUN on `start_i` when both `line_length_i` and `num_lines_i` are nonzero.
  - IDLE → DONE on `start_i` when either is zero. No address is issued.
  - RUN → DONE on the handshake of the last word of the last line.
  - DONE → IDLE unconditionally; `done_o` = 1 in DONE.
- **Handshake.**
  - `addr_valid_o = (state == RUN) & enable_i`.
  - Counters advance only on `addr_valid_o & addr_ready_i`.
  - `addr_o`, `strb_o` and `ctrl_realign_o` stay stable while valid is high and ready is low.
- **Counters.**
  - Word counter wraps W-1 → 0 and increments the line counter.
  - The last word of the last line transitions to DONE and does not increment.
- **Start gating.** `start_i` in RUN or DONE is ignored.
- **`enable_i` low.** FSM, counters and latched config hold; `addr_valid_o` = 0.

## Timing
- **Reset / clear values.** On reset or clear, all outputs go to 0:
  - `addr_valid_o`, `busy_o`, `done_o` = 0.
  - `addr_o`, `strb_o` = 0.
  - `ctrl_realign_o` = '0.
  - State = IDLE, counters = 0.
- **Priority.** `rst_ni` > `clear_i` > `enable_i` > normal operation. Clear in mid-job aborts without a `done_o` pulse.
- **Start latency.**
  - First `addr_valid_o` appears in the cycle after `start_i`.
  - Zero-length jobs pulse `done_o` in the cycle after `start_i`.
- **Throughput.** One address per cycle with `addr_ready_i` held high.
- **Done.** `done_o` is high for exactly one cycle, the one after the final handshake. `busy_o` is high in RUN and DONE.
- **Output decode.** Outputs are combinational decodes of registered state and counters. There is no combinational path from `addr_ready_i` to any output.
- **Boundaries.**
  - Misaligned job with `line_length_i = 1`: W = 2; word 0 carries first, word 1 carries last.
  - Aligned job with `line_length_i = 1`: first and last are both 1 on the single word.
  - `last_packet` asserts only on the single final word of the job.

## Structure
- **`hwpe_stream_package`.**
  - Reuses existing `ctrl_realign_t`.
  - Adds `addressgen_state_t` enum: IDLE, RUN, DONE.
- **Module body.** Single module, no sub-module.
  - Registers: config latch, word counter, line counter, `line_base` register, FSM.
  - Combinational decode of strobes and ctrl.
  - Estimated size about 200 lines.

## Test plan
- **Aligned job.** base 0x1000, length 4, lines 2, stride 0x40, ready = 1 → addresses 0x1000, 0x1004, 0x1008, 0x100C, 0x1040 … 0x104C. `strb` is 0xF throughout. `realign` = 0. `last_packet` is set only on 0x104C. `done_o` pulses one cycle later.
- **Misaligned job.** base 0x1003, length 3, lines 1 → addresses 0x1000, 0x1004, 0x1008, 0x100C. Strobes 0x8, 0xF, 0xF, 0x7. `realign` = 1. `first` only on the first word; `last` and `last_packet` on the fourth.
- **Backpressure.** Drive `addr_ready_i` in the pattern 1,0,0,1 on the misaligned job → outputs are held stable during stalls, no word is skipped or duplicated, and exactly 4 handshakes occur.
- **Zero length.** `start_i` with `num_lines_i = 0` → no `addr_valid_o`; `done_o` = 1 in the cycle after start; back to IDLE.
- **Clear and enable.** Pull `enable_i` low mid-line → valid drops and the counter holds; it resumes at the same address. Assert `clear_i` mid-job → the next cycle shows all outputs 0 and no `done_o` pulse. Assert `rst_ni` low mid-job → same result on the next edge.
- **Stride wrap.** base 0xFFFFFFF0, stride 0x20, lines 2, length 1 → second line address 0x00000010.

Source files
------------

// File: rtl/hwpe_stream_package.sv
// Shared types for the HWPE stream blocks: the realigner control word and
// the state encoding of the realign address generator.
package hwpe_stream_package;

  typedef struct packed {
    logic        enable;
    logic        realign;
    logic        first;
    logic        last;
    logic        last_packet;
    logic [15:0] line_length;
  } ctrl_realign_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } addressgen_state_t;

endpackage

// File: rtl/hwpe_stream_realign_addressgen.sv
// Word-aligned TCDM address generator for misaligned load streams; emits the
// byte strobe and realigner control that accompany every issued word.
module hwpe_stream_realign_addressgen
  import hwpe_stream_package::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic                    enable_i,
  input  logic                    start_i,
  input  logic [31:0]             base_addr_i,
  input  logic [CNT_WIDTH-1:0]    line_length_i,
  input  logic [CNT_WIDTH-1:0]    num_lines_i,
  input  logic [31:0]             line_stride_i,
  input  logic                    addr_ready_i,
  output logic [31:0]             addr_o,
  output logic                    addr_valid_o,
  output logic [DATA_WIDTH/8-1:0] strb_o,
  output ctrl_realign_t           ctrl_realign_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned OFF_W = $clog2(BYTES);
  localparam logic [BYTES-1:0] STRB_ALL = '1;

  addressgen_state_t    r_state;
  logic [OFF_W-1:0]     r_off;
  logic                 r_misaligned;
  logic [CNT_WIDTH-1:0] r_line_length;
  logic [CNT_WIDTH:0]   r_words_m1;
  logic [CNT_WIDTH-1:0] r_lines_m1;
  logic [31:0]          r_stride;
  logic [31:0]          r_line_base;
  logic [CNT_WIDTH:0]   r_word_cnt;
  logic [CNT_WIDTH-1:0] r_line_cnt;

  logic [OFF_W-1:0] w_base_off;
  logic             w_base_mis;
  logic             w_job_empty;
  logic             w_run;
  logic             w_handshake;
  logic             w_first;
  logic             w_last_word;
  logic             w_last_line;
  logic [31:0]      w_word_offset;
  logic             w_unused_stride_lsb;

  assign w_base_off  = base_addr_i[OFF_W-1:0];
  assign w_base_mis  = (w_base_off != '0);
  assign w_job_empty = (line_length_i == '0) || (num_lines_i == '0);

  assign w_run        = (r_state == RUN);
  assign addr_valid_o = w_run & enable_i;
  assign w_handshake  = addr_valid_o & addr_ready_i;
  assign busy_o       = (r_state != IDLE);
  assign done_o       = (r_state == DONE);

  assign w_first     = (r_word_cnt == '0);
  assign w_last_word = (r_word_cnt == r_words_m1);
  assign w_last_line = (r_line_cnt == r_lines_m1);

  assign w_word_offset       = 32'(r_word_cnt) << OFF_W;
  assign w_unused_stride_lsb = ^line_stride_i[OFF_W-1:0];

  // A misaligned line needs one extra word, so the word counter is one bit wider.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      r_state       <= IDLE;
      r_off         <= '0;
      r_misaligned  <= 1'b0;
      r_line_length <= '0;
      r_words_m1    <= '0;
      r_lines_m1    <= '0;
      r_stride      <= '0;
      r_line_base   <= '0;
      r_word_cnt    <= '0;
      r_line_cnt    <= '0;
    end else if (enable_i) begin
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_off         <= w_base_off;
            r_misaligned  <= w_base_mis;
            r_line_length <= line_length_i;
            r_words_m1    <= {1'b0, line_length_i} + (CNT_WIDTH+1)'(w_base_mis)
                             - (CNT_WIDTH+1)'(1);
            r_lines_m1    <= num_lines_i - CNT_WIDTH'(1);
            r_stride      <= {line_stride_i[31:OFF_W], {OFF_W{1'b0}}};
            r_line_base   <= {base_addr_i[31:OFF_W], {OFF_W{1'b0}}};
            r_word_cnt    <= '0;
            r_line_cnt    <= '0;
            r_state       <= w_job_empty ? DONE : RUN;
          end
        end
        RUN: begin
          if (w_handshake) begin
            if (!w_last_word) begin
              r_word_cnt <= r_word_cnt + (CNT_WIDTH+1)'(1);
            end else if (w_last_line) begin
              r_state <= DONE;
            end else begin
              r_word_cnt  <= '0;
              r_line_cnt  <= r_line_cnt + CNT_WIDTH'(1);
              r_line_base <= r_line_base + r_stride;
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Word 0 of a misaligned line keeps the bytes at and above the offset; the
  // extra trailing word keeps the bytes below it.
  always_comb begin
    addr_o                = '0;
    strb_o                = '0;
    ctrl_realign_o        = '0;
    ctrl_realign_o.enable = busy_o;
    if (w_run) begin
      addr_o = r_line_base + w_word_offset;
      if (!r_misaligned) begin
        strb_o = STRB_ALL;
      end else if (w_first) begin
        strb_o = STRB_ALL << r_off;
      end else if (w_last_word) begin
        strb_o = ~(STRB_ALL << r_off);
      end else begin
        strb_o = STRB_ALL;
      end
      ctrl_realign_o.realign     = r_misaligned;
      ctrl_realign_o.first       = w_first;
      ctrl_realign_o.last        = w_last_word;
      ctrl_realign_o.last_packet = w_last_word & w_last_line;
      ctrl_realign_o.line_length = 16'(r_line_length);
    end
  end

endmodule
